// File: rtl/etapa_busqueda.sv
// MIPS instruction-fetch stage: PC register, req/ack fetch from instruction memory, one-entry buffer to decode.
// Optional macro ETAPA_BUSQUEDA_ALINEACION_EN adds misaligned-PC detection with an ERROR state.
module etapa_busqueda #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_siguiente,
  input  logic        flush,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_dato,
  output logic [31:0] pc_mas4,
  output logic        imem_req,
  output logic [31:0] imem_dir,
  output logic [31:0] instr,
  output logic [31:0] pc_instr,
  output logic        instr_valida,
  output logic        error_alineacion
);

  typedef enum logic [1:0] {
    PEDIR     = 2'd0,
    LLENO     = 2'd1,
    DESCARTAR = 2'd2
`ifdef ETAPA_BUSQUEDA_ALINEACION_EN
    , ERROR   = 2'd3
`endif
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dir_pend_q, dir_pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_instr_q, pc_instr_d;
  logic        valida_q, valida_d;
  logic        desalineado;

`ifdef ETAPA_BUSQUEDA_ALINEACION_EN
  logic        err_q, err_d;
  assign desalineado      = (pc_q[1:0] != 2'b00);
  assign error_alineacion = err_q;
`else
  assign desalineado      = 1'b0;
  assign error_alineacion = 1'b0;
`endif

  assign pc_mas4      = pc_q + 32'd4;
  assign instr        = instr_q;
  assign pc_instr     = pc_instr_q;
  assign instr_valida = valida_q;
  // While discarding, the abandoned address must stay on the bus until its ack arrives.
  assign imem_dir     = (estado_q == DESCARTAR) ? dir_pend_q : pc_q;
  assign imem_req     = !reset &&
                        (((estado_q == PEDIR) && !desalineado) || (estado_q == DESCARTAR));

  always_comb begin
    estado_d   = estado_q;
    pc_d       = pc_q;
    dir_pend_d = dir_pend_q;
    instr_d    = instr_q;
    pc_instr_d = pc_instr_q;
    valida_d   = valida_q;
`ifdef ETAPA_BUSQUEDA_ALINEACION_EN
    err_d      = err_q;
`endif
    case (estado_q)
      PEDIR: begin
`ifdef ETAPA_BUSQUEDA_ALINEACION_EN
        // A redirect arriving with the misaligned PC replaces it before any fault is raised.
        if (desalineado) begin
          if (flush) begin
            pc_d = pc_siguiente;
          end else begin
            estado_d = ERROR;
            err_d    = 1'b1;
          end
        end else
`endif
        if (imem_ack) begin
          pc_d = pc_siguiente;
          if (!flush) begin
            instr_d    = imem_dato;
            pc_instr_d = pc_q;
            valida_d   = 1'b1;
            estado_d   = LLENO;
          end
        end else if (flush) begin
          dir_pend_d = pc_q;
          pc_d       = pc_siguiente;
          estado_d   = DESCARTAR;
        end
      end
      LLENO: begin
        if (flush) begin
          valida_d = 1'b0;
          pc_d     = pc_siguiente;
          estado_d = PEDIR;
        end else if (!stall) begin
          valida_d = 1'b0;
          estado_d = PEDIR;
        end
      end
      DESCARTAR: begin
        if (flush) pc_d = pc_siguiente;
        if (imem_ack) estado_d = PEDIR;
      end
`ifdef ETAPA_BUSQUEDA_ALINEACION_EN
      ERROR: begin
        if (flush) begin
          pc_d     = pc_siguiente;
          err_d    = 1'b0;
          estado_d = PEDIR;
        end
      end
`endif
      default: estado_d = PEDIR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= PEDIR;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc_instr_q <= 32'h0;
      valida_q   <= 1'b0;
`ifdef ETAPA_BUSQUEDA_ALINEACION_EN
      err_q      <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_instr_q <= pc_instr_d;
      valida_q   <= valida_d;
`ifdef ETAPA_BUSQUEDA_ALINEACION_EN
      err_q      <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    dir_pend_q <= dir_pend_d;
  end

endmodule
